// File: rtl/pc_sequencer.sv
// Program-flow controller: owns the PC and run/halt/step control, and holds a
// small hardware return stack for call/ret. It faults on stack misuse.
module pc_sequencer #(
    parameter int Psize  = 6,
    parameter int Sdepth = 4
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             run,
    input  logic             step,
    input  logic             stall,
    input  logic             brEn,
    input  logic [1:0]       condSel,
    input  logic             zFlag,
    input  logic             cFlag,
    input  logic             call,
    input  logic             ret,
    input  logic             haltReq,
    input  logic [Psize-1:0] brTarget,
    output logic [Psize-1:0] pcOut,
    output logic             cwValid,
    output logic [2:0]       state,
    output logic             stackErr
);

    localparam int SPW = $clog2(Sdepth + 1);
    localparam int AW  = (Sdepth > 1) ? $clog2(Sdepth) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        RUN   = 3'b001,
        HALT  = 3'b010,
        STEP  = 3'b011,
        FAULT = 3'b100
    } state_t;

    typedef struct packed {
        logic             br;
        logic [1:0]       cond;
        logic             call;
        logic             ret;
        logic             halt;
        logic [Psize-1:0] tgt;
    } cw_t;

    state_t           cur, nxt;
    cw_t              cw;
    logic [Psize-1:0] pc, pc_nxt, pc_inc;
    logic [SPW-1:0]   sp, sp_nxt;
    logic [Psize-1:0] stk [Sdepth];
    logic [AW-1:0]    top_idx, push_idx;
    logic             push, fault, cond_ok, stk_empty, stk_full;

    assign cw       = '{br: brEn, cond: condSel, call: call, ret: ret,
                        halt: haltReq, tgt: brTarget};
    assign pc_inc   = pc + Psize'(1);
    assign stk_empty = (sp == '0);
    assign stk_full  = (sp == SPW'(Sdepth));
    assign top_idx   = AW'(sp - SPW'(1));
    assign push_idx  = AW'(sp);

    always_comb begin
        case (cw.cond)
            2'b00:   cond_ok = 1'b1;
            2'b01:   cond_ok = zFlag;
            2'b10:   cond_ok = !zFlag;
            default: cond_ok = cFlag;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            cur      <= IDLE;
            pc       <= '0;
            sp       <= '0;
            stackErr <= 1'b0;
        end else begin
            cur <= nxt;
            pc  <= pc_nxt;
            sp  <= sp_nxt;
            if (fault)
                stackErr <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < Sdepth; i++)
                stk[i] <= '0;
        end else if (push) begin
            stk[push_idx] <= pc_inc;
        end
    end

    // Control-word fields act only on a committed word; a fault freezes PC and stack.
    always_comb begin
        nxt    = cur;
        pc_nxt = pc;
        sp_nxt = sp;
        push   = 1'b0;
        fault  = 1'b0;
        case (cur)
            IDLE: if (run) nxt = RUN;
            RUN:  if (!run) nxt = HALT;
            HALT: begin
                if (run)
                    nxt = RUN;
                else if (step)
                    nxt = STEP;
            end
            STEP: if (!stall) nxt = HALT;
            default: nxt = cur;
        endcase
        if (cwValid) begin
            if (cw.halt)
                nxt = HALT;
            if (cw.call && cw.ret) begin
                fault = 1'b1;
            end else if (cw.ret) begin
                if (stk_empty) begin
                    fault = 1'b1;
                end else begin
                    pc_nxt = stk[top_idx];
                    sp_nxt = sp - SPW'(1);
                end
            end else if (cw.call) begin
                if (stk_full) begin
                    fault = 1'b1;
                end else begin
                    push   = 1'b1;
                    sp_nxt = sp + SPW'(1);
                    pc_nxt = cw.tgt;
                end
            end else if (cw.br && cond_ok) begin
                pc_nxt = cw.tgt;
            end else begin
                pc_nxt = pc_inc;
            end
            if (fault)
                nxt = FAULT;
        end
    end

    always_comb begin
        cwValid = ((cur == RUN) || (cur == STEP)) && !stall;
        state   = cur;
        pcOut   = pc;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench: stimulus queues expected commit PCs and status snapshots;
// a negedge monitor pops and compares them against the DUT.
module tb_pc_sequencer;

    localparam logic [2:0] S_IDLE = 3'd0, S_RUN = 3'd1, S_HALT = 3'd2,
                           S_STEP = 3'd3, S_FAULT = 3'd4;

    bit         clk;
    logic       nReset, run, step, stall, brEn, zFlag, cFlag, call, ret, haltReq;
    logic [1:0] condSel;
    logic [5:0] brTarget, pcOut;
    logic       cwValid, stackErr;
    logic [2:0] state;

    pc_sequencer #(.Psize(6), .Sdepth(4)) dut (
        .clk(clk), .nReset(nReset), .run(run), .step(step), .stall(stall),
        .brEn(brEn), .condSel(condSel), .zFlag(zFlag), .cFlag(cFlag),
        .call(call), .ret(ret), .haltReq(haltReq), .brTarget(brTarget),
        .pcOut(pcOut), .cwValid(cwValid), .state(state), .stackErr(stackErr)
    );

    always #5 clk = ~clk;

    logic [5:0]  exp_q [$];
    logic [10:0] chk_q [$];
    string       nm_q  [$];
    int          n_cmp = 0, n_err = 0;
    bit          done  = 0;

    logic [5:0]  m_pc;
    logic [10:0] m_exp, m_act;
    string       m_nm;

    always @(negedge clk) begin
        if (cwValid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL commit_unexpected: got commit at pc %0d, required no commit", pcOut);
            end else begin
                m_pc = exp_q.pop_front();
                if (pcOut !== m_pc) begin
                    n_err++;
                    $display("FAIL commit_pc: got %0d, required %0d", pcOut, m_pc);
                end
            end
        end else if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            m_pc = exp_q.pop_front();
            $display("FAIL commit_missing: got cwValid=0, required commit of pc %0d", m_pc);
        end
        while (chk_q.size() != 0) begin
            m_exp = chk_q.pop_front();
            m_nm  = nm_q.pop_front();
            m_act = {state, pcOut, stackErr, cwValid};
            n_cmp++;
            if (m_act !== m_exp) begin
                n_err++;
                $display("FAIL %s: got state=%0d pc=%0d err=%0d cv=%0d, required state=%0d pc=%0d err=%0d cv=%0d",
                         m_nm, m_act[10:8], m_act[7:2], m_act[1], m_act[0],
                         m_exp[10:8], m_exp[7:2], m_exp[1], m_exp[0]);
            end
        end
        if (done) begin
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [2:0] st, input logic [5:0] p,
                       input logic er, input logic cv);
        chk_q.push_back({st, p, er, cv});
        nm_q.push_back(nm);
    endtask

    task automatic word(input logic [5:0] pc, input logic b, input logic [1:0] cs,
                        input logic zz, input logic cc, input logic cl, input logic rt,
                        input logic hr, input logic [5:0] tgt);
        brEn = b; condSel = cs; zFlag = zz; cFlag = cc;
        call = cl; ret = rt; haltReq = hr; brTarget = tgt;
        exp_q.push_back(pc);
        tick();
        brEn = 0; call = 0; ret = 0; haltReq = 0;
    endtask

    task automatic inc(input logic [5:0] pc);
        word(pc, 0, 2'b00, 0, 0, 0, 0, 0, 6'd0);
    endtask

    task automatic callw(input logic [5:0] pc, input logic [5:0] tgt);
        word(pc, 0, 2'b00, 0, 0, 1, 0, 0, tgt);
    endtask

    task automatic retw(input logic [5:0] pc);
        word(pc, 0, 2'b00, 0, 0, 0, 1, 0, 6'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        nReset = 0;
        run = 0; step = 0; stall = 0; brEn = 0; call = 0; ret = 0; haltReq = 0;
        #1;
        chk("reset", S_IDLE, 6'd0, 0, 0);
        tick();
        tick();
        nReset = 1;
    endtask

    task automatic start_run();
        run = 1;
        chk("idle", S_IDLE, 6'd0, 0, 0);
        tick();
        chk("run_start", S_RUN, 6'd0, 0, 1);
    endtask

    initial begin
        nReset = 0; run = 0; step = 0; stall = 0; brEn = 0; condSel = 0;
        zFlag = 0; cFlag = 0; call = 0; ret = 0; haltReq = 0; brTarget = 0;
        do_reset();
        start_run();

        // free run across the 63 -> 0 wrap
        for (int i = 0; i < 69; i++)
            inc(6'(i % 64));

        // conditional branches: Z not set / Z set / !Z with Z set / C set
        word(6'd5,  1, 2'b01, 0, 0, 0, 0, 0, 6'd20);
        word(6'd6,  1, 2'b01, 1, 0, 0, 0, 0, 6'd20);
        word(6'd20, 1, 2'b10, 1, 0, 0, 0, 0, 6'd50);
        word(6'd21, 1, 2'b11, 0, 1, 0, 0, 0, 6'd3);

        callw(6'd3, 6'd40);
        retw(6'd40);

        // stall holds PC and defers the branch
        word(6'd4, 1, 2'b00, 0, 0, 0, 0, 0, 6'd9);
        stall = 1; brEn = 1; condSel = 2'b00; brTarget = 6'd33;
        for (int i = 0; i < 3; i++) begin
            chk("stall_hold", S_RUN, 6'd9, 0, 0);
            tick();
        end
        stall = 0;
        word(6'd9, 1, 2'b00, 0, 0, 0, 0, 0, 6'd12);

        // haltReq, single step, stalled step, held step
        word(6'd12, 0, 2'b00, 0, 0, 0, 0, 1, 6'd0);
        chk("halt_req", S_HALT, 6'd13, 0, 0);
        run = 0;
        tick();
        chk("halt_hold", S_HALT, 6'd13, 0, 0);
        step = 1;
        tick();
        step = 0;
        chk("step_enter", S_STEP, 6'd13, 0, 1);
        inc(6'd13);
        chk("step_done", S_HALT, 6'd14, 0, 0);
        step = 1;
        tick();
        step = 0; stall = 1;
        chk("step_stall1", S_STEP, 6'd14, 0, 0);
        tick();
        chk("step_stall2", S_STEP, 6'd14, 0, 0);
        tick();
        stall = 0;
        inc(6'd14);
        chk("step_after_stall", S_HALT, 6'd15, 0, 0);
        step = 1;
        tick();
        inc(6'd15);
        chk("held_step_halt", S_HALT, 6'd16, 0, 0);
        tick();
        step = 0;
        chk("held_step_again", S_STEP, 6'd16, 0, 1);
        inc(6'd16);

        // resume, then run=0 still commits the current word
        run = 1;
        chk("resume_halt", S_HALT, 6'd17, 0, 0);
        tick();
        chk("resume_run", S_RUN, 6'd17, 0, 1);
        inc(6'd17);
        run = 0;
        inc(6'd18);
        chk("run_drop", S_HALT, 6'd19, 0, 0);
        run = 1;
        tick();

        // fill the stack (incl. wrapped return address 0), then overflow
        callw(6'd19, 6'd40);
        callw(6'd40, 6'd50);
        callw(6'd50, 6'd63);
        callw(6'd63, 6'd10);
        retw(6'd10);
        callw(6'd0, 6'd2);
        callw(6'd2, 6'd33);
        chk("overflow_fault", S_FAULT, 6'd2, 1, 0);
        brEn = 1; brTarget = 6'd7;
        tick();
        chk("fault_hold", S_FAULT, 6'd2, 1, 0);
        tick();
        brEn = 0;

        // reset mid-stall with two stack entries, then underflow
        do_reset();
        start_run();
        callw(6'd0, 6'd25);
        callw(6'd25, 6'd30);
        stall = 1;
        chk("pre_reset_stall", S_RUN, 6'd30, 0, 0);
        do_reset();
        start_run();
        retw(6'd0);
        chk("underflow_fault", S_FAULT, 6'd0, 1, 0);

        // call and ret on the same word
        do_reset();
        start_run();
        word(6'd0, 0, 2'b00, 0, 0, 1, 1, 0, 6'd9);
        chk("callret_fault", S_FAULT, 6'd0, 1, 0);
        tick();
        done = 1;
    end

endmodule
